passcode_checker: RTL and testbench

//  Responder side of the lock controller's code-check interface. Collects digit presses,

---
 rtl/lock_pkg.sv | 26 ++
 rtl/passcode_checker_if.sv | 35 +++
 rtl/code_entry_buffer.sv | 72 +++++++
 rtl/passcode_checker.sv | 198 +++++++++++++++++++
 tb/tb_passcode_checker.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller and the passcode checker:
// compare-type codes, key codes, digit width and the checker FSM states.
package lock_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        COMPAREPC = 2'd0,
        COMPAREUC = 2'd1,
        MATCHUC   = 2'd2,
        STOREUC   = 2'd3
    } cmp_type_e;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd6;
    localparam logic [3:0] KEY_CANCEL    = 4'd7;
    localparam logic [3:0] KEY_PROG      = 4'd8;
    localparam logic [3:0] KEY_LOCK      = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_COMPARE,
        S_DONE
    } state_e;

endpackage

// File: rtl/passcode_checker_if.sv
// Code-check link between the lock FSM (master) and the passcode checker
// (slave), plus the debounced keypad lines. locked_out exists only when
// LOCKOUT_EN is defined.
interface passcode_checker_if;
    logic [3:0] button;
    logic       bstate;
    logic       read_input;
    logic [1:0] compareType;
    logic       store;
    logic       correct_input;
    logic       data_ready;
    logic       validLength;
    logic       validLengthPC;
`ifdef LOCKOUT_EN
    logic       locked_out;

    modport master (
        output button, bstate, read_input, compareType, store,
        input  correct_input, data_ready, validLength, validLengthPC, locked_out
    );
    modport slave (
        input  button, bstate, read_input, compareType, store,
        output correct_input, data_ready, validLength, validLengthPC, locked_out
    );
`else
    modport master (
        output button, bstate, read_input, compareType, store,
        input  correct_input, data_ready, validLength, validLengthPC
    );
    modport slave (
        input  button, bstate, read_input, compareType, store,
        output correct_input, data_ready, validLength, validLengthPC
    );
`endif
endinterface

// File: rtl/code_entry_buffer.sv
// Keypad entry buffer: detects presses (bstate falling), appends digit keys
// at index count while enabled, saturates with an overflow flag, and keeps
// registered length-validity flags.
module code_entry_buffer
    import lock_pkg::*;
#(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 6,
    parameter int PC_LEN  = 6,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                              hwclk,
    input  logic                              reset,
    input  logic [3:0]                        button,
    input  logic                              bstate,
    input  logic                              read_input,
    input  logic                              enable,
    input  logic                              clear,
    output logic [MAX_LEN-1:0][DIGIT_W-1:0]   digits,
    output logic [CNT_W-1:0]                  count,
    output logic                              overflow,
    output logic                              valid_len,
    output logic                              valid_len_pc
);

    logic bstate_q;
    logic press;
    logic append;

    // Previous key-held level; a press is held-then-released.
    always_ff @(posedge hwclk) begin
        if (reset) bstate_q <= 1'b0;
        else       bstate_q <= bstate;
    end

    // A press landing in the read_input fall cycle sees read_input=0 and is dropped.
    assign press  = bstate_q & ~bstate;
    assign append = enable & press & read_input & (button <= KEY_DIGIT_MAX);

    // Entry length with saturation; the digit past MAX_LEN only flags overflow.
    always_ff @(posedge hwclk) begin
        if (reset || clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (append) begin
            if (count == CNT_W'(MAX_LEN)) overflow <= 1'b1;
            else                          count    <= count + 1'b1;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_slot
        // Slot g captures the digit pressed while count==g.
        always_ff @(posedge hwclk) begin
            if (reset || clear)
                digits[g] <= '0;
            else if (append && count == CNT_W'(g))
                digits[g] <= button[DIGIT_W-1:0];
        end
    end

    // Length flags trail count by one cycle; sampled by the controller later.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            valid_len    <= 1'b0;
            valid_len_pc <= 1'b0;
        end else begin
            valid_len    <= !overflow && count >= CNT_W'(MIN_LEN) && count <= CNT_W'(MAX_LEN);
            valid_len_pc <= !overflow && count == CNT_W'(PC_LEN);
        end
    end

endmodule

// File: rtl/passcode_checker.sv
// Passcode checker: collects an entry through code_entry_buffer, then
// compares it digit-serially against the programming code, the user code
// or a pending candidate, and commits the candidate to the user code on
// store. Optional macro LOCKOUT_EN adds a failed-attempt lockout.
module passcode_checker
    import lock_pkg::*;
#(
    parameter int                         MIN_LEN     = 4,
    parameter int                         MAX_LEN     = 6,
    parameter int                         PC_LEN      = 6,
    parameter logic [MAX_LEN*DIGIT_W-1:0] PROG_CODE   = 24'h654321,
    parameter logic [MAX_LEN*DIGIT_W-1:0] DEFAULT_UC  = 24'h004321,
    parameter int                         DEFAULT_LEN = 4
`ifdef LOCKOUT_EN
    ,
    parameter int                         MAX_FAILS   = 3,
    parameter logic [23:0]                LOCK_CYCLES = 24'd12_000_000
`endif
) (
    input logic                hwclk,
    input logic                reset,
    passcode_checker_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] digits_t;

    state_e            state, state_n;
    logic              ri_q, rise, fall;
    logic [1:0]        ctype, ctype_n;
    logic [CNT_W-1:0]  idx, idx_n;
    logic              data_ready, dr_n, correct, cor_n;
    logic              clear, finish, pass, store_cand;
    digits_t           digits, uc, cand, tgt;
    logic [CNT_W-1:0]  count, uc_len, cand_len, tgt_len;
    logic              overflow, valid_len, valid_len_pc, len_ok;
    logic              cand_valid, tgt_ok;
    logic              locked;

    code_entry_buffer #(
        .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PC_LEN(PC_LEN), .CNT_W(CNT_W)
    ) u_buf (
        .hwclk(hwclk), .reset(reset), .button(bus.button), .bstate(bus.bstate),
        .read_input(bus.read_input), .enable(state == S_ENTRY), .clear(clear),
        .digits(digits), .count(count), .overflow(overflow),
        .valid_len(valid_len), .valid_len_pc(valid_len_pc)
    );

    assign rise   = bus.read_input & ~ri_q;
    assign fall   = ~bus.read_input & ri_q;
    assign len_ok = !overflow && count >= CNT_W'(MIN_LEN) && count <= CNT_W'(MAX_LEN);

    // Pick the reference code for the latched compare type.
    always_comb begin
        tgt     = uc;
        tgt_len = uc_len;
        tgt_ok  = 1'b1;
        case (ctype)
            COMPAREPC: begin tgt = PROG_CODE; tgt_len = CNT_W'(PC_LEN); end
            MATCHUC:   begin tgt = cand; tgt_len = cand_len; tgt_ok = cand_valid; end
            default:   ;
        endcase
    end

    // Next state and result: digit-serial compare, stopping on first mismatch.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        ctype_n    = ctype;
        dr_n       = data_ready;
        cor_n      = correct;
        clear      = 1'b0;
        finish     = 1'b0;
        pass       = 1'b0;
        store_cand = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (rise) begin
                    clear   = 1'b1;
                    dr_n    = 1'b0;
                    cor_n   = 1'b0;
                    state_n = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (fall) begin
                    ctype_n = bus.compareType;
                    idx_n   = '0;
                    state_n = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (ctype == STOREUC) begin
                    store_cand = 1'b1;
                    finish     = 1'b1;
                    pass       = len_ok;
                end else if (!tgt_ok || overflow || count != tgt_len) begin
                    finish = 1'b1;
                end else if (digits[idx] != tgt[idx]) begin
                    finish = 1'b1;
                end else if (idx == tgt_len - 1'b1) begin
                    finish = 1'b1;
                    pass   = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
                if (finish) begin
                    state_n = S_DONE;
                    dr_n    = 1'b1;
                    cor_n   = pass & ~locked;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM and result registers.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state      <= S_IDLE;
            ri_q       <= 1'b0;
            ctype      <= 2'd0;
            idx        <= '0;
            data_ready <= 1'b0;
            correct    <= 1'b0;
        end else begin
            state      <= state_n;
            ri_q       <= bus.read_input;
            ctype      <= ctype_n;
            idx        <= idx_n;
            data_ready <= dr_n;
            correct    <= cor_n;
        end
    end

    // Code registers: store commits the candidate; a fresh STOREUC wins a same-cycle tie.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            uc         <= DEFAULT_UC;
            uc_len     <= CNT_W'(DEFAULT_LEN);
            cand       <= '0;
            cand_len   <= '0;
            cand_valid <= 1'b0;
        end else begin
            if (bus.store && cand_valid) begin
                uc         <= cand;
                uc_len     <= cand_len;
                cand_valid <= 1'b0;
            end
            if (store_cand) begin
                cand       <= digits;
                cand_len   <= count;
                cand_valid <= len_ok;
            end
        end
    end

`ifdef LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    logic [FAIL_W-1:0] fail_cnt;
    logic [23:0]       lock_timer;

    // Consecutive user-code failures arm a fixed-length lockout.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            fail_cnt   <= '0;
            locked     <= 1'b0;
            lock_timer <= '0;
        end else if (locked) begin
            lock_timer <= lock_timer - 1'b1;
            if (lock_timer == 24'd1) begin
                locked   <= 1'b0;
                fail_cnt <= '0;
            end
        end else if (finish && ctype == COMPAREUC) begin
            if (pass) begin
                fail_cnt <= '0;
            end else if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                fail_cnt   <= FAIL_W'(MAX_FAILS);
                locked     <= 1'b1;
                lock_timer <= LOCK_CYCLES;
            end else begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign bus.locked_out = locked;
`else
    assign locked = 1'b0;
`endif

    assign bus.correct_input = correct;
    assign bus.data_ready    = data_ready;
    assign bus.validLength   = valid_len;
    assign bus.validLengthPC = valid_len_pc;

endmodule

// File: tb/tb_passcode_checker.sv
// Self-checking bench for passcode_checker: directed scenarios followed by
// randomized entries, checked against a queue-based model of the codes.
module tb_passcode_checker;
    import lock_pkg::*;

    logic hwclk = 1'b0;
    logic reset;
    always #5 hwclk = ~hwclk;

    passcode_checker_if bus();
    passcode_checker dut (.hwclk(hwclk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    int pc_m[$];
    int uc_m[$];
    int cand_m[$];
    int ent[$];
    int keys[$];
    bit cand_v;
    bit ovf;

    task automatic cyc();
        @(posedge hwclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int k);
        bus.button = 4'(k);
        bus.bstate = 1'b1;
        cyc();
        bus.bstate = 1'b0;
        cyc();
        cyc();
    endtask

    // Commits the pending candidate when one is valid; held several cycles.
    task automatic store_pulse();
        bus.store = 1'b1;
        cyc(); cyc(); cyc();
        bus.store = 1'b0;
        cyc();
        if (cand_v) begin
            uc_m   = cand_m;
            cand_v = 1'b0;
        end
    endtask

    // One full entry of `keys` followed by a compare of type ct.
    task automatic run_entry(input int ct, input bit late_press);
        int  tgt[$];
        int  exp_c, exp_lat, n;
        bit  vl, vpc, tok;
        bus.read_input = 1'b1;
        cyc();
        chk("dr_clear", bus.data_ready, 0);
        cyc();
        ent.delete();
        ovf = 1'b0;
        foreach (keys[i]) begin
            press(keys[i]);
            if (keys[i] <= 6) begin
                if (ent.size() >= 6) ovf = 1'b1;
                else                 ent.push_back(keys[i]);
            end
        end
        cyc(); cyc();
        vl  = !ovf && ent.size() >= 4 && ent.size() <= 6;
        vpc = !ovf && ent.size() == 6;
        chk("valid_len", bus.validLength, 32'(vl));
        chk("valid_len_pc", bus.validLengthPC, 32'(vpc));
        bus.compareType = 2'(ct);
        if (late_press) begin
            bus.button = 4'd5;
            bus.bstate = 1'b1;
            cyc();
            bus.bstate = 1'b0;
        end
        bus.read_input = 1'b0;
        if (ct == 3) begin
            exp_c   = int'(vl);
            exp_lat = 2;
        end else begin
            if (ct == 0)      tgt = pc_m;
            else if (ct == 1) tgt = uc_m;
            else              tgt = cand_m;
            tok = !(ct == 2 && !cand_v);
            if (!tok || ovf || ent.size() != tgt.size()) begin
                exp_c   = 0;
                exp_lat = 2;
            end else begin
                exp_c   = 1;
                exp_lat = tgt.size() + 1;
                for (int i = 0; i < tgt.size(); i++) begin
                    if (ent[i] != tgt[i]) begin
                        exp_c   = 0;
                        exp_lat = i + 2;
                        break;
                    end
                end
            end
        end
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 12) begin
            cyc();
            n++;
        end
        chk("data_ready", bus.data_ready, 1);
        chk("latency", n, exp_lat);
        chk("correct", bus.correct_input, exp_c);
        cyc();
        chk("correct_held", bus.correct_input, exp_c);
        if (ct == 3) begin
            cand_m = ent;
            cand_v = vl;
        end
    endtask

    initial begin
        int mode, len, ct;
        pc_m   = '{1, 2, 3, 4, 5, 6};
        uc_m   = '{1, 2, 3, 4};
        cand_m = {};
        cand_v = 1'b0;
        reset           = 1'b1;
        bus.button      = 4'd0;
        bus.bstate      = 1'b0;
        bus.read_input  = 1'b0;
        bus.compareType = 2'd0;
        bus.store       = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_data_ready", bus.data_ready, 0);
        chk("rst_correct", bus.correct_input, 0);
        chk("rst_valid_len", bus.validLength, 0);
        chk("rst_valid_len_pc", bus.validLengthPC, 0);
        reset = 1'b0;
        cyc();

        // Programming code, short entry, overflow.
        keys = '{1, 2, 3, 4, 5, 6};    run_entry(0, 1'b0);
        keys = '{1, 2, 3};             run_entry(1, 1'b0);
        keys = '{1, 2, 3, 4, 5, 6, 2}; run_entry(0, 1'b0);
        keys = '{7, 1, 8, 2, 9, 3, 4}; run_entry(1, 1'b0);

        // Program a new user code.
        keys = '{5, 5, 5, 5}; run_entry(3, 1'b0);
        keys = '{5, 5, 5, 5}; run_entry(2, 1'b0);
        store_pulse();
        keys = '{5, 5, 5, 5}; run_entry(1, 1'b0);
        keys = '{1, 2, 3, 4}; run_entry(1, 1'b0);

        // Press coincident with the read_input fall is ignored.
        keys = '{5, 5, 5, 5}; run_entry(1, 1'b1);

        // Reset during a compare that would otherwise finish next cycle.
        bus.read_input = 1'b1;
        cyc(); cyc();
        press(1); press(2); press(3);
        bus.compareType = 2'd1;
        bus.read_input  = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst_mid_data_ready", bus.data_ready, 0);
        reset = 1'b0;
        uc_m   = '{1, 2, 3, 4};
        cand_v = 1'b0;
        cyc();
        keys = '{1, 2, 3, 4}; run_entry(1, 1'b0);
        keys = '{5, 5, 5, 5}; run_entry(1, 1'b0);

        // Randomized entries against the model.
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 3));
            keys.delete();
            case (mode)
                1: keys = pc_m;
                2: keys = uc_m;
                3: begin
                    if (cand_m.size() > 0) keys = cand_m;
                    else repeat (4) keys.push_back(int'($urandom_range(0, 6)));
                end
                default: begin
                    len = int'($urandom_range(0, 7));
                    repeat (len) keys.push_back(int'($urandom_range(0, 9)));
                end
            endcase
            ct = int'($urandom_range(0, 3));
            run_entry(ct, 1'b0);
            if ($urandom_range(0, 3) == 0) store_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
